// File: rtl/ov7670_sccb_sender.sv
// ---------------------------------------------------------------------------
// ov7670_sccb_sender
//
// Write-only SCCB master for OV7670 bring-up. It sits directly behind the
// register-table ROM. Each 16-bit {register, value} entry is sent as one
// 3-phase write to DEVICE_ID. After each write, `advance` steps the table.
// When the table reports `finished`, the block parks in DONE.
//
// Bus timing is built from "quarters" of QUARTER clk cycles each:
//   START : 2 quarters (SDA falls while SCL high, then SCL low)
//   BITS  : 27 bits x 4 quarters (SCL low, low, high, high)
//   STOP  : 3 quarters (SCL low, SCL high, then SDA rises)
// That is 113 quarters per write. An idle GAP of GAP_CYCLES follows each
// write.
//
// Ports
//   clk          sole clock
//   rst          synchronous active-high reset; aborts any write in flight
//   command      [15:8] register address, [7:0] value (table ROM output)
//   finished     table exhausted
//   advance      1-cycle pulse on the first GAP cycle after a completed STOP
//   sioc         SCCB clock
//   siod_o       SCCB data out
//   siod_oe      1 = drive siod_o, 0 = release (ACK / don't-care bits)
//   busy         high in START, BITS, STOP and GAP
//   config_done  sticky, set once `finished` is seen in IDLE
// ---------------------------------------------------------------------------
module ov7670_sccb_sender #(
    parameter int         QUARTER    = 250,
    parameter int         GAP_CYCLES = 1000,
    parameter logic [7:0] DEVICE_ID  = 8'h42
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] command,
    input  logic        finished,
    output logic        advance,
    output logic        sioc,
    output logic        siod_o,
    output logic        siod_oe,
    output logic        busy,
    output logic        config_done
);

    // QUARTER == 1 would give a zero-width counter; keep at least one bit.
    localparam int             QW       = (QUARTER > 1) ? $clog2(QUARTER) : 1;
    localparam int             GW       = $clog2(GAP_CYCLES + 1);
    localparam logic [QW-1:0]  Q_LAST   = QW'(QUARTER - 1);
    localparam logic [QW-1:0]  Q_ONE    = QW'(1);
    localparam logic [GW-1:0]  G_LAST   = GW'(GAP_CYCLES - 1);
    localparam logic [GW-1:0]  G_ONE    = GW'(1);
    localparam logic [4:0]     LAST_BIT = 5'd26;

    typedef enum logic [2:0] {
        S_GAP,
        S_IDLE,
        S_START,
        S_BITS,
        S_STOP,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } cmd_t;

    state_t         state;
    logic [QW-1:0]  q_cnt;     // cycle within the current quarter
    logic [1:0]     q_ph;      // quarter index within START/bit/STOP
    logic [4:0]     bit_idx;   // 0..26, MSB first
    logic [26:0]    shreg;     // frame; bit 26 is the bit currently on the bus
    logic [GW-1:0]  gap_cnt;
    cmd_t           cmd;
    logic           q_end;

    assign cmd   = cmd_t'(command);
    assign q_end = (q_cnt == Q_LAST);

    // The 9th bit of each byte is left to the slave. The bus is released
    // for the whole bit, and whatever comes back is ignored.
    function automatic logic is_ack(input logic [4:0] idx);
        return (idx == 5'd8) || (idx == 5'd17) || (idx == 5'd26);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            // The gap restarts from zero. This gives the ROM time to leave
            // its post-reset output before IDLE samples `command`.
            state       <= S_GAP;
            q_cnt       <= '0;
            q_ph        <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            gap_cnt     <= '0;
            sioc        <= 1'b1;
            siod_o      <= 1'b1;
            siod_oe     <= 1'b1;
            advance     <= 1'b0;
            busy        <= 1'b1;
            config_done <= 1'b0;
        end else begin
            advance <= 1'b0;
            case (state)
                // Idle bus. The gap also covers the ROM's advance->command latency.
                S_GAP: begin
                    if (gap_cnt == G_LAST) begin
                        gap_cnt <= '0;
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + G_ONE;
                    end
                end

                // Single-cycle decision. This is the only cycle that
                // looks at `command` or `finished`.
                S_IDLE: begin
                    if (finished) begin
                        state       <= S_DONE;
                        config_done <= 1'b1;
                    end else begin
                        shreg   <= {DEVICE_ID, 1'b1, cmd.addr, 1'b1, cmd.data, 1'b1};
                        state   <= S_START;
                        q_cnt   <= '0;
                        q_ph    <= '0;
                        busy    <= 1'b1;
                        sioc    <= 1'b1;
                        siod_o  <= 1'b0;   // START: SDA falls while SCL high
                        siod_oe <= 1'b1;
                    end
                end

                S_START: begin
                    if (!q_end) begin
                        q_cnt <= q_cnt + Q_ONE;
                    end else begin
                        q_cnt <= '0;
                        if (q_ph == 2'd0) begin
                            q_ph <= 2'd1;
                            sioc <= 1'b0;
                        end else begin
                            state   <= S_BITS;
                            q_ph    <= 2'd0;
                            bit_idx <= '0;
                            siod_o  <= shreg[26];
                            siod_oe <= 1'b1;   // bit 0 is never an ACK slot
                        end
                    end
                end

                // Data changes only at the Q3->Q0 boundary. SCL is low in
                // the following quarter, so SDA is stable whenever SCL is high.
                S_BITS: begin
                    if (!q_end) begin
                        q_cnt <= q_cnt + Q_ONE;
                    end else begin
                        q_cnt <= '0;
                        q_ph  <= q_ph + 2'd1;   // 3 wraps to 0 for the next bit
                        case (q_ph)
                            2'd1: sioc <= 1'b1;
                            2'd3: begin
                                sioc <= 1'b0;
                                if (bit_idx == LAST_BIT) begin
                                    state   <= S_STOP;
                                    siod_o  <= 1'b0;
                                    siod_oe <= 1'b1;
                                end else begin
                                    bit_idx <= bit_idx + 5'd1;
                                    shreg   <= {shreg[25:0], 1'b0};
                                    siod_o  <= shreg[25];
                                    siod_oe <= !is_ack(bit_idx + 5'd1);
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                S_STOP: begin
                    if (!q_end) begin
                        q_cnt <= q_cnt + Q_ONE;
                    end else begin
                        q_cnt <= '0;
                        q_ph  <= q_ph + 2'd1;
                        case (q_ph)
                            2'd0: sioc   <= 1'b1;
                            2'd1: siod_o <= 1'b1;   // STOP: SDA rises while SCL high
                            2'd2: begin
                                state   <= S_GAP;
                                q_ph    <= 2'd0;
                                gap_cnt <= '0;
                                advance <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end

                S_DONE: begin
                    sioc        <= 1'b1;
                    siod_o      <= 1'b1;
                    siod_oe     <= 1'b1;
                    busy        <= 1'b0;
                    config_done <= 1'b1;
                end

                default: state <= S_GAP;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_sccb_sender.sv
// ---------------------------------------------------------------------------
// tb_ov7670_sccb_sender
//
// Bench for ov7670_sccb_sender, run with QUARTER=2 and GAP_CYCLES=8.
// A behavioural table ROM has a 2-cycle advance->command latency. An
// optional override on `command` lets the bench disturb the input outside
// IDLE. Stimulus pushes the expected {device, register, value} of each write
// into a queue. A separate bus monitor decodes SCCB frames and pops and
// checks the queue at each STOP.
// ---------------------------------------------------------------------------
module tb_ov7670_sccb_sender;

    localparam int Q    = 2;
    localparam int G    = 8;
    localparam int SPAN = 224;   // START fall to STOP rise, in clk cycles

    typedef struct packed {
        logic [7:0] dev;
        logic [7:0] addr;
        logic [7:0] data;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] command;
    logic        finished;
    logic        advance, sioc, siod_o, siod_oe, busy, config_done;

    always #5 clk = ~clk;

    ov7670_sccb_sender #(.QUARTER(Q), .GAP_CYCLES(G), .DEVICE_ID(8'h42)) dut (
        .clk(clk), .rst(rst), .command(command), .finished(finished),
        .advance(advance), .sioc(sioc), .siod_o(siod_o), .siod_oe(siod_oe),
        .busy(busy), .config_done(config_done)
    );

    // ---------------- table ROM model ----------------
    logic [15:0] rom [0:31];
    logic [4:0]  rom_idx;
    logic [15:0] rom_stg, rom_cmd;
    logic        glitch = 1'b0;
    logic [15:0] gval   = 16'h0000;

    always @(posedge clk) begin
        if (rst) begin
            rom_idx <= '0;
            rom_stg <= 16'h0000;
            rom_cmd <= 16'h0000;
        end else begin
            if (advance) rom_idx <= rom_idx + 5'd1;
            rom_stg <= rom[rom_idx];
            rom_cmd <= rom_stg;
        end
    end

    assign command  = glitch ? gval : rom_cmd;
    assign finished = (command == 16'hFFFF);

    // ---------------- scoreboard / bookkeeping ----------------
    frame_t exp_q[$];
    int n_vec = 0, n_err = 0;
    int adv_cnt = 0, frame_cnt = 0, toggle_cnt = 0, stray = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // ---------------- bus monitor ----------------
    logic        prev_sioc = 1'b1, prev_bus = 1'b1, skip = 1'b1, in_frame = 1'b0, bus;
    logic [26:0] bits, oe_bits;
    int          nbits = 0, cyc = 0, t_start = 0, oe0 = 0, illegal = 0;

    task automatic end_frame();
        frame_t got, e;
        got = '{dev: bits[26:19], addr: bits[17:10], data: bits[8:1]};
        frame_cnt++;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_frame: got %0h, want none", got);
        end else begin
            e = exp_q.pop_front();
            check("frame_bytes", 64'(got), 64'(e));
        end
        check("frame_bits", 64'(nbits), 64'd27);
        check("frame_oe_pattern", 64'(oe_bits), 64'h7FBFDFE);
        check("frame_ack_level", {bits[18], bits[9], bits[0]}, 3'b111);
        check("frame_span", 64'(cyc - t_start), 64'(SPAN));
        check("ack_release_cycles", 64'(oe0), 64'd24);
        check("bus_legal", 64'(illegal), 64'd0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            bus = siod_oe ? siod_o : 1'b1;
            if (rst) begin
                in_frame = 1'b0;   // aborted frame is discarded
                skip     = 1'b1;
            end else if (skip) begin
                skip = 1'b0;
            end else begin
                if (advance) adv_cnt++;
                if (sioc != prev_sioc && !in_frame) toggle_cnt++;
                if (bus != prev_bus && sioc) begin
                    if (prev_sioc && !bus) begin
                        in_frame = 1'b1; nbits = 0; bits = '0; oe_bits = '0;
                        t_start = cyc; oe0 = 0; illegal = 0;
                    end else if (prev_sioc && bus && in_frame) begin
                        end_frame();
                        in_frame = 1'b0;
                    end else if (in_frame) begin
                        illegal++;
                    end else begin
                        stray++;
                    end
                end
                if (in_frame && sioc && !prev_sioc && nbits < 27) begin
                    bits[26-nbits]    = bus;
                    oe_bits[26-nbits] = siod_oe;
                    nbits++;
                end
                if (in_frame && !siod_oe) oe0++;
            end
            prev_sioc = sioc;
            prev_bus  = bus;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick(1);
        rst = 1'b1; glitch = 1'b0;
        adv_cnt = 0; frame_cnt = 0; toggle_cnt = 0; stray = 0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic push(input int idx, input logic [15:0] c);
        rom[idx] = c;
        exp_q.push_back('{dev: 8'h42, addr: c[15:8], data: c[7:0]});
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!config_done && n < budget) begin
            tick(1);
            n++;
        end
        check("config_done", 64'(config_done), 64'd1);
    endtask

    task automatic end_checks(input string tag, input int n_writes);
        check({tag, "_advances"}, 64'(adv_cnt), 64'(n_writes));
        check({tag, "_frames"}, 64'(frame_cnt), 64'(n_writes));
        check({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
        check({tag, "_stray_edges"}, 64'(stray), 64'd0);
    endtask

    logic [15:0] tbl [0:19] = '{16'h1280, 16'h1204, 16'h1100, 16'h0C00, 16'h3E00,
                                16'h8C00, 16'h0400, 16'h40D0, 16'h3A04, 16'h1438,
                                16'h4F40, 16'h5034, 16'h510C, 16'h5217, 16'h5329,
                                16'h5440, 16'h581E, 16'h3DC0, 16'h1714, 16'h1802};

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 16'hFFFF;

        // 1: single entry 16'h1280, plus reset values
        push(0, 16'h1280);
        rom[1] = 16'hFFFF;
        do_reset();
        check("reset_outputs", {sioc, siod_o, siod_oe, advance, busy, config_done}, 6'b111010);
        wait_done(2000);
        end_checks("single", 1);

        // 2/3: full 20-entry table, then end marker
        for (int i = 0; i < 20; i++) push(i, tbl[i]);
        rom[20] = 16'hFFFF;
        do_reset();
        wait_done(10000);
        end_checks("table", 20);

        // 5: finished from the very first IDLE
        rom[0] = 16'hFFFF;
        do_reset();
        tick(G);
        check("early_cfg_pre", 64'(config_done), 64'd0);
        tick(1);
        check("early_cfg_set", 64'(config_done), 64'd1);
        check("early_busy", 64'(busy), 64'd0);
        tick(40);
        check("early_sioc_toggles", 64'(toggle_cnt), 64'd0);
        check("early_frames", 64'(frame_cnt), 64'd0);
        check("early_busy_hold", {busy, sioc, siod_o, siod_oe}, 4'b0111);

        // 4: reset during bit 12 of 16'h3A14, then a full re-send
        push(0, 16'h3A14);
        rom[1] = 16'hFFFF;
        do_reset();
        tick(G + 103);
        check("abort_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        tick(1);
        check("abort_bus_idle", {sioc, siod_o, siod_oe, advance}, 4'b1110);
        tick(1);
        rst = 1'b0;
        wait_done(2000);
        end_checks("abort", 1);

        // 6: command disturbed in the first GAP, in BITS and in the post-write GAP
        push(0, 16'h5533);
        rom[1] = 16'hFFFF;
        do_reset();
        glitch = 1'b1; gval = 16'hFFFF;
        tick(G);
        glitch = 1'b0;                     // real value present in IDLE
        tick(20);
        glitch = 1'b1; gval = 16'hFFFF;
        tick(150);
        gval = 16'h0000;
        tick(57);                          // first GAP cycle after STOP
        gval = 16'h1234;
        tick(7);
        glitch = 1'b0;                     // next IDLE sees the table's 0xFFFF
        wait_done(2000);
        end_checks("glitch", 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
